alu_ctrl_seq: RTL and testbench

ALU_CTRL_SEQ -- requirements
Module: alu_ctrl_seq

---
 rtl/alu_ctrl_seq.sv | 98 +++++++++
 tb/tb_alu_ctrl_seq.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/alu_ctrl_seq.sv
// alu_ctrl_seq: ALU select decode with RV32M sequencing (ports: clk, rst_n, valid_i, funct7, funct3, alu_op -> alu_sel_o, md_start_o, busy_o, done_o, illegal_o)
module alu_ctrl_seq #(
  parameter int SEL_W   = 5,
  parameter int M_EXT   = 1,
  parameter int MUL_LAT = 2,
  parameter int DIV_LAT = 33
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_i,
  input  logic [6:0]       funct7,
  input  logic [2:0]       funct3,
  input  logic [1:0]       alu_op,
  output logic [SEL_W-1:0] alu_sel_o,
  output logic             md_start_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             illegal_o
);
  localparam logic [1:0] S_IDLE = 2'd0, S_MD_RUN = 2'd1, S_DONE = 2'd2;
  logic [1:0]       state_q, state_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic             start_q, start_d, done_q, done_d, ill_q, ill_d;
  logic [4:0]       base_op, op;
  logic             is_m, r_ill, i_ill, illegal;
  always_comb begin
    base_op = 5'd0;
    case (funct3)
      3'b000: base_op = (alu_op == 2'b10 && funct7[5]) ? 5'd1 : 5'd0;
      3'b001: base_op = 5'd2;
      3'b010: base_op = 5'd3;
      3'b011: base_op = 5'd4;
      3'b100: base_op = 5'd5;
      3'b101: base_op = funct7[5] ? 5'd7 : 5'd6;
      3'b110: base_op = 5'd8;
      default: base_op = 5'd9;
    endcase
  end
  assign is_m = alu_op == 2'b10 && funct7 == 7'b0000001 && M_EXT != 0;
  assign r_ill = funct7 != 7'b0 && !is_m &&
                 !(funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101));
  assign i_ill = (funct3 == 3'b001 && funct7 != 7'b0) ||
                 (funct3 == 3'b101 && funct7 != 7'b0 && funct7 != 7'b0100000);
  assign illegal = alu_op == 2'b10 ? r_ill : alu_op == 2'b11 ? i_ill : 1'b0;
  // M ops encode as 16+funct3
  assign op = illegal ? 5'd0 : alu_op == 2'b00 ? 5'd0 : alu_op == 2'b01 ? 5'd1 :
              is_m ? {2'b10, funct3} : base_op;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    start_d = 1'b0;
    done_d  = 1'b0;
    ill_d   = 1'b0;
    case (state_q)
      S_IDLE: if (valid_i) begin
        sel_d = SEL_W'(op);
        if (is_m) begin
          state_d = S_MD_RUN;
          start_d = 1'b1;
          cnt_d   = funct3[2] ? 8'(DIV_LAT) : 8'(MUL_LAT);
        end else begin
          done_d = 1'b1;
          ill_d  = illegal;
        end
      end
      S_MD_RUN: begin
        state_d = cnt_q == 8'd1 ? S_DONE : S_MD_RUN;
        done_d  = cnt_q == 8'd1;
        cnt_d   = cnt_q == 8'd1 ? cnt_q : cnt_q - 8'd1;
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      sel_q   <= '0;
      start_q <= 1'b0;
      done_q  <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      start_q <= start_d;
      done_q  <= done_d;
      ill_q   <= ill_d;
    end
  end
  assign alu_sel_o  = sel_q;
  assign md_start_o = start_q;
  assign busy_o     = state_q == S_MD_RUN;
  assign done_o     = done_q;
  assign illegal_o  = ill_q;
endmodule

// File: tb/tb_alu_ctrl_seq.sv
// tb_alu_ctrl_seq: directed self-checking bench for alu_ctrl_seq
module tb_alu_ctrl_seq;
  logic       clk, rst_n, valid_i;
  logic [6:0] funct7;
  logic [2:0] funct3;
  logic [1:0] alu_op;
  logic [4:0] alu_sel_o, nm_sel;
  logic       md_start_o, busy_o, done_o, illegal_o;
  logic       nm_start, nm_busy, nm_done, nm_ill, nm_started;
  int         n_chk, n_fail;
  alu_ctrl_seq u_dut (
    .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .funct7(funct7), .funct3(funct3),
    .alu_op(alu_op), .alu_sel_o(alu_sel_o), .md_start_o(md_start_o), .busy_o(busy_o),
    .done_o(done_o), .illegal_o(illegal_o)
  );
  alu_ctrl_seq #(.M_EXT(0)) u_nm (
    .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .funct7(funct7), .funct3(funct3),
    .alu_op(alu_op), .alu_sel_o(nm_sel), .md_start_o(nm_start), .busy_o(nm_busy),
    .done_o(nm_done), .illegal_o(nm_ill)
  );
  always #5 clk = ~clk;
  always @(negedge clk) if (nm_start) nm_started = 1'b1;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic [1:0] op, input logic [2:0] f3, input logic [6:0] f7);
    alu_op  = op;
    funct3  = f3;
    funct7  = f7;
    valid_i = 1'b1;
  endtask
  task automatic base(input string tag, input logic [1:0] op, input logic [2:0] f3,
                      input logic [6:0] f7, input int sel, input logic ill);
    drive(op, f3, f7);
    step();
    valid_i = 1'b0;
    check({tag, "_sel"}, alu_sel_o, sel);
    check({tag, "_done"}, done_o, 1);
    check({tag, "_ill"}, illegal_o, ill);
    check({tag, "_start"}, md_start_o, 0);
    check({tag, "_busy"}, busy_o, 0);
    step();
    check({tag, "_done_clr"}, done_o, 0);
    check({tag, "_ill_clr"}, illegal_o, 0);
    check({tag, "_sel_hold"}, alu_sel_o, sel);
  endtask
  initial begin
    int starts, done_at;
    logic second;
    clk = 0; rst_n = 0; valid_i = 0; alu_op = 0; funct3 = 0; funct7 = 0;
    nm_started = 0; n_chk = 0; n_fail = 0;
    repeat (2) step();
    check("rst_sel", alu_sel_o, 0);
    check("rst_start", md_start_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_done", done_o, 0);
    check("rst_ill", illegal_o, 0);
    rst_n = 1'b1;
    base("r_sub", 2'b10, 3'b000, 7'b0100000, 1, 1'b0);
    base("r_sltu", 2'b10, 3'b011, 7'b0000000, 4, 1'b0);
    base("r_bad_sll", 2'b10, 3'b001, 7'b0100000, 0, 1'b1);
    base("i_sra", 2'b11, 3'b101, 7'b0100000, 7, 1'b0);
    base("i_bad_slli", 2'b11, 3'b001, 7'b0100000, 0, 1'b1);
    base("r_and", 2'b10, 3'b111, 7'b0000000, 9, 1'b0);
    base("i_ori", 2'b11, 3'b110, 7'b1111111, 8, 1'b0);
    base("op_add", 2'b00, 3'b111, 7'b1111111, 0, 1'b0);
    base("op_sub", 2'b01, 3'b000, 7'b0000000, 1, 1'b0);
    base("r_srl", 2'b10, 3'b101, 7'b0000000, 6, 1'b0);
    base("r_bad_f7", 2'b10, 3'b000, 7'b0000010, 0, 1'b1);
    base("i_bad_srli", 2'b11, 3'b101, 7'b0000001, 0, 1'b1);
    base("i_slli", 2'b11, 3'b001, 7'b0000000, 2, 1'b0);
    base("i_addi_f7", 2'b11, 3'b000, 7'b0100000, 0, 1'b0);
    // MUL on the M-enabled unit; same request is illegal on the M_EXT=0 unit
    drive(2'b10, 3'b000, 7'b0000001);
    step();
    valid_i = 1'b0;
    check("mul_c1_start", md_start_o, 1);
    check("mul_c1_busy", busy_o, 1);
    check("mul_c1_done", done_o, 0);
    check("mul_sel", alu_sel_o, 16);
    check("nm_ill", nm_ill, 1);
    check("nm_done", nm_done, 1);
    check("nm_sel", nm_sel, 0);
    step();
    check("mul_c2_start", md_start_o, 0);
    check("mul_c2_busy", busy_o, 1);
    check("mul_c2_done", done_o, 0);
    check("nm_done_clr", nm_done, 0);
    step();
    check("mul_c3_done", done_o, 1);
    check("mul_c3_busy", busy_o, 0);
    check("mul_c3_ill", illegal_o, 0);
    step();
    check("mul_c4_done", done_o, 0);
    // REM with valid held: one start, done at 34, restart only once back in IDLE
    drive(2'b10, 3'b110, 7'b0000001);
    starts = 0; done_at = 0; second = 1'b0;
    for (int c = 1; c <= 36; c++) begin
      step();
      if (c == 36) valid_i = 1'b0;
      if (md_start_o) begin
        if (c <= 35) starts++;
        else second = 1'b1;
      end
      if (done_o && done_at == 0) done_at = c;
    end
    check("rem_starts", starts, 1);
    check("rem_done_at", done_at, 34);
    check("rem_restart", second, 1);
    check("rem_sel", alu_sel_o, 22);
    for (int c = 0; c < 40 && !done_o; c++) step();
    check("rem2_done", done_o, 1);
    step();
    // DIV aborted by reset at cycle 10
    drive(2'b10, 3'b100, 7'b0000001);
    step();
    valid_i = 1'b0;
    check("div_start", md_start_o, 1);
    check("div_sel", alu_sel_o, 20);
    repeat (9) step();
    check("div_c10_busy", busy_o, 1);
    #1 rst_n = 1'b0;
    #1;
    check("abort_busy", busy_o, 0);
    check("abort_sel", alu_sel_o, 0);
    check("abort_start", md_start_o, 0);
    check("abort_done", done_o, 0);
    check("abort_ill", illegal_o, 0);
    for (int c = 0; c < 3; c++) begin
      step();
      check("abort_nodone", done_o, 0);
    end
    rst_n = 1'b1;
    base("post_add", 2'b00, 3'b000, 7'b0000000, 0, 1'b0);
    base("post_and", 2'b10, 3'b111, 7'b0000000, 9, 1'b0);
    check("nm_never_start", nm_started, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
